tt_um_jleugeri_ttt_host_sequencer: RTL and testbench

//  Host-side initiator for the ttt main controller. Buffers external token events, feeds them
//  to the main block with instruction 0001 while it is in stage 00, then issues advance (0010).

---
 rtl/tt_um_jleugeri_ttt_host_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_host_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_jleugeri_ttt_host_sequencer.sv
// Host-side sequencer: feeds buffered token events to the ttt main block,
// advances it, and captures emitted events. Optional: TTT_SEQ_WATCHDOG_EN.
module tt_um_jleugeri_ttt_host_sequencer #(
  parameter int NUM_PROCESSORS = 10,
  parameter int NEW_TOKEN_BITS = 4,
  parameter int IN_DEPTH       = 4,
  parameter int OUT_DEPTH      = 8,
  parameter int STEP_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int PW            = $clog2(NUM_PROCESSORS),
  localparam int NTB           = NEW_TOKEN_BITS
) (
  input  logic                 clock_fast,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PW-1:0]        in_proc_id,
  input  logic [NTB-1:0]       in_good,
  input  logic [NTB-1:0]       in_bad,
  input  logic                 step_req,
  output logic                 step_ack,
  output logic [STEP_BITS-1:0] step_count,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_proc_id,
  output logic [1:0]           out_startstop,
  output logic                 out_overflow,
  output logic                 seq_error,
  output logic [3:0]           ttt_instruction,
  output logic [PW-1:0]        ttt_processor_id,
  output logic [NTB-1:0]       ttt_good,
  output logic [NTB-1:0]       ttt_bad,
  input  logic [1:0]           ttt_stage,
  input  logic [PW-1:0]        ttt_proc_id_out,
  input  logic [1:0]           ttt_startstop,
  input  logic                 ttt_output_valid
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int OCW = $clog2(OUT_DEPTH + 1);
  localparam int IDW = PW + 2 * NTB;
  localparam int ODW = PW + 2;

  typedef enum logic [1:0] {
    S_IDLE, S_FEED, S_LEAVE, S_RUN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDW-1:0] r_in_mem [IN_DEPTH];
  logic [IAW-1:0] r_in_wr;
  logic [IAW-1:0] r_in_rd;
  logic [ICW-1:0] r_in_cnt;
  logic [ODW-1:0] r_out_mem [OUT_DEPTH];
  logic [OAW-1:0] r_out_wr;
  logic [OAW-1:0] r_out_rd;
  logic [OCW-1:0] r_out_cnt;

  logic [3:0]           r_instr;
  logic [PW-1:0]        r_pid;
  logic [NTB-1:0]       r_good;
  logic [NTB-1:0]       r_bad;
  logic                 r_ack;
  logic [STEP_BITS-1:0] r_steps;
  logic                 r_ovf;

  logic           w_in_empty;
  logic           w_in_push;
  logic           w_in_pop;
  logic           w_out_full;
  logic           w_out_pop;
  logic           w_out_push;
  logic           w_cap;
  logic           w_done;
  logic           w_wd_hit;
  logic [3:0]     w_instr;
  logic [PW-1:0]  w_pid;
  logic [NTB-1:0] w_good;
  logic [NTB-1:0] w_bad;
  logic [ODW-1:0] w_out_head;

  assign w_in_empty = (r_in_cnt == '0);
  assign in_ready   = (r_in_cnt != ICW'(IN_DEPTH));
  assign w_in_push  = in_valid && in_ready;

  assign w_out_full = (r_out_cnt == OCW'(OUT_DEPTH));
  assign out_valid  = (r_out_cnt != '0);
  assign w_out_pop  = out_valid && out_ready;
  assign w_cap      = (r_state == S_RUN) && ttt_output_valid;
  assign w_out_push = w_cap && (!w_out_full || w_out_pop);
  assign w_out_head = r_out_mem[r_out_rd];

  assign out_proc_id   = out_valid ? w_out_head[ODW-1:2] : '0;
  assign out_startstop = out_valid ? w_out_head[1:0] : 2'b00;

  always_comb begin
    w_next   = r_state;
    w_instr  = 4'b0000;
    w_pid    = '0;
    w_good   = '0;
    w_bad    = '0;
    w_in_pop = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (step_req && ttt_stage == 2'b00) w_next = S_FEED;
      end
      S_FEED: begin
        if (!w_in_empty) begin
          w_instr  = 4'b0001;
          {w_pid, w_good, w_bad} = r_in_mem[r_in_rd];
          w_in_pop = 1'b1;
        end else begin
          w_instr = 4'b0010;
          w_next  = S_LEAVE;
        end
      end
      S_LEAVE: begin
        if (ttt_stage != 2'b00) w_next = S_RUN;
        else if (w_wd_hit)      w_next = S_IDLE;
      end
      S_RUN: begin
        if (ttt_stage == 2'b00) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else if (w_wd_hit) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_instr   <= 4'b0000;
      r_pid     <= '0;
      r_good    <= '0;
      r_bad     <= '0;
      r_ack     <= 1'b0;
      r_steps   <= '0;
      r_ovf     <= 1'b0;
      r_in_wr   <= '0;
      r_in_rd   <= '0;
      r_in_cnt  <= '0;
      r_out_wr  <= '0;
      r_out_rd  <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_instr <= w_instr;
      r_pid   <= w_pid;
      r_good  <= w_good;
      r_bad   <= w_bad;
      r_ack   <= w_done;
      if (w_done) r_steps <= r_steps + 1'b1;
      if (w_cap && w_out_full && !w_out_pop) r_ovf <= 1'b1;
      if (w_in_push) r_in_wr <= r_in_wr + 1'b1;
      if (w_in_pop)  r_in_rd <= r_in_rd + 1'b1;
      r_in_cnt <= r_in_cnt + ICW'(w_in_push) - ICW'(w_in_pop);
      if (w_out_push) r_out_wr <= r_out_wr + 1'b1;
      if (w_out_pop)  r_out_rd <= r_out_rd + 1'b1;
      r_out_cnt <= r_out_cnt + OCW'(w_out_push) - OCW'(w_out_pop);
    end
  end

  // Storage needs no reset: the counts gate every read.
  always_ff @(posedge clock_fast) begin
    if (w_in_push)  r_in_mem[r_in_wr]   <= {in_proc_id, in_good, in_bad};
    if (w_out_push) r_out_mem[r_out_wr] <= {ttt_proc_id_out, ttt_startstop};
  end

`ifdef TTT_SEQ_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] r_wd;
  logic           r_err;

  assign w_wd_hit = (r_state == S_LEAVE || r_state == S_RUN)
                 && (r_wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_next != r_state) r_wd <= '0;
      else if (r_state == S_LEAVE || r_state == S_RUN) r_wd <= r_wd + 1'b1;
      if (w_wd_hit && w_next == S_IDLE && !w_done) r_err <= 1'b1;
    end
  end

  assign seq_error = r_err;
`else
  assign w_wd_hit  = 1'b0;
  assign seq_error = 1'b0;
`endif

  assign ttt_instruction  = r_instr;
  assign ttt_processor_id = r_pid;
  assign ttt_good         = r_good;
  assign ttt_bad          = r_bad;
  assign step_ack         = r_ack;
  assign step_count       = r_steps;
  assign out_overflow     = r_ovf;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_host_sequencer.sv
// Directed bench for the ttt host sequencer; the bench drives ttt_stage
// by hand in place of the main block.
module tb_tt_um_jleugeri_ttt_host_sequencer;

  logic        clock_fast = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_proc_id;
  logic [3:0]  in_good;
  logic [3:0]  in_bad;
  logic        step_req;
  logic        step_ack;
  logic [15:0] step_count;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_proc_id;
  logic [1:0]  out_startstop;
  logic        out_overflow;
  logic        seq_error;
  logic [3:0]  ttt_instruction;
  logic [3:0]  ttt_processor_id;
  logic [3:0]  ttt_good;
  logic [3:0]  ttt_bad;
  logic [1:0]  ttt_stage;
  logic [3:0]  ttt_proc_id_out;
  logic [1:0]  ttt_startstop;
  logic        ttt_output_valid;

  int checks = 0;
  int errors = 0;

  tt_um_jleugeri_ttt_host_sequencer dut (
    .clock_fast(clock_fast), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_proc_id(in_proc_id), .in_good(in_good), .in_bad(in_bad),
    .step_req(step_req), .step_ack(step_ack), .step_count(step_count),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_proc_id(out_proc_id), .out_startstop(out_startstop),
    .out_overflow(out_overflow), .seq_error(seq_error),
    .ttt_instruction(ttt_instruction), .ttt_processor_id(ttt_processor_id),
    .ttt_good(ttt_good), .ttt_bad(ttt_bad), .ttt_stage(ttt_stage),
    .ttt_proc_id_out(ttt_proc_id_out), .ttt_startstop(ttt_startstop),
    .ttt_output_valid(ttt_output_valid)
  );

  always #5 clock_fast = ~clock_fast;

  task automatic step();
    @(posedge clock_fast);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] id, input logic [3:0] g,
                      input logic [3:0] b);
    in_valid = 1'b1; in_proc_id = id; in_good = g; in_bad = b;
    step();
    in_valid = 1'b0;
  endtask

  int err_at;
  int seen_ack;

  initial begin
    reset = 1'b1; in_valid = 0; in_proc_id = 0; in_good = 0; in_bad = 0;
    step_req = 0; out_ready = 0; ttt_stage = 0; ttt_proc_id_out = 0;
    ttt_startstop = 0; ttt_output_valid = 0;
    repeat (3) step();
    chk("rst_instr", ttt_instruction, 0);
    chk("rst_count", step_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ack", step_ack, 0);
    chk("rst_ovf", out_overflow, 0);
    chk("rst_err", seq_error, 0);
    reset = 1'b0;
    step();

    // 1: two events fed, then advance, then stage round trip
    push(4'd3, 4'd2, 4'd0);
    push(4'd7, 4'hF, 4'd1);
    step_req = 1; step(); step_req = 0;
    chk("t1_feed_idle", ttt_instruction, 0);
    step();
    chk("t1_ev0_instr", ttt_instruction, 4'b0001);
    chk("t1_ev0_id", ttt_processor_id, 3);
    chk("t1_ev0_good", ttt_good, 2);
    chk("t1_ev0_bad", ttt_bad, 0);
    step();
    chk("t1_ev1_instr", ttt_instruction, 4'b0001);
    chk("t1_ev1_id", ttt_processor_id, 7);
    chk("t1_ev1_good", ttt_good, 4'hF);
    chk("t1_ev1_bad", ttt_bad, 1);
    step();
    chk("t1_adv", ttt_instruction, 4'b0010);
    step();
    chk("t1_adv_once", ttt_instruction, 0);
    ttt_stage = 2'b01; step();
    ttt_stage = 2'b10; step();
    chk("t1_no_ack_yet", step_ack, 0);
    ttt_stage = 2'b00; step();
    chk("t1_ack", step_ack, 1);
    chk("t1_count", step_count, 1);
    step();
    chk("t1_ack_pulse", step_ack, 0);

    // 2: empty input FIFO, advance right after one FEED cycle
    step_req = 1; step(); step_req = 0;
    step();
    chk("t2_adv", ttt_instruction, 4'b0010);
    ttt_stage = 2'b01; step();
    ttt_stage = 2'b00; step();
    chk("t2_ack", step_ack, 1);
    chk("t2_count", step_count, 2);

    // 3: nine emitted events into an 8-deep FIFO
    ttt_output_valid = 1; ttt_proc_id_out = 4'd9; step();
    ttt_output_valid = 0;
    chk("t3_idle_ignored", out_valid, 0);
    step_req = 1; step(); step_req = 0;
    step();
    ttt_stage = 2'b01; step();
    for (int i = 0; i < 9; i++) begin
      ttt_output_valid = 1;
      ttt_proc_id_out = 4'(i);
      ttt_startstop = 2'(i);
      step();
    end
    ttt_output_valid = 0;
    ttt_stage = 2'b00; step();
    chk("t3_count", step_count, 3);
    chk("t3_ovf", out_overflow, 1);
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_pop_valid", out_valid, 1);
      chk("t3_pop_id", out_proc_id, 32'(i));
      chk("t3_pop_ss", out_startstop, 32'(i % 4));
      step();
    end
    out_ready = 0;
    chk("t3_drained", out_valid, 0);
    chk("t3_ovf_sticky", out_overflow, 1);

    // 4: fill input FIFO, reject the 5th, push while popping
    for (int i = 0; i < 4; i++) push(4'(i), 4'(i + 1), 4'd0);
    chk("t4_full", in_ready, 0);
    push(4'd4, 4'd0, 4'd0);
    step_req = 1; step(); step_req = 0;
    step();
    chk("t4_ev0", ttt_processor_id, 0);
    chk("t4_ready_after_pop", in_ready, 1);
    in_valid = 1; in_proc_id = 4'd9; in_good = 4'd5; in_bad = 4'd6;
    step(); in_valid = 0;
    chk("t4_ev1", ttt_processor_id, 1);
    step();
    chk("t4_ev2", ttt_processor_id, 2);
    step();
    chk("t4_ev3", ttt_processor_id, 3);
    step();
    chk("t4_ev4_id", ttt_processor_id, 9);
    chk("t4_ev4_good", ttt_good, 5);
    step();
    chk("t4_adv", ttt_instruction, 4'b0010);
    ttt_stage = 2'b01; step();
    ttt_stage = 2'b00; step();
    chk("t4_count", step_count, 4);

    // 5: reset during RUN
    step_req = 1; step(); step_req = 0;
    step();
    ttt_stage = 2'b01; step();
    in_valid = 1; in_proc_id = 4'd5;
    ttt_output_valid = 1; ttt_proc_id_out = 4'd2;
    step();
    in_valid = 0; ttt_output_valid = 0;
    chk("t5_captured", out_valid, 1);
    reset = 1; step();
    chk("t5_instr", ttt_instruction, 0);
    chk("t5_count", step_count, 0);
    chk("t5_out_empty", out_valid, 0);
    chk("t5_ovf", out_overflow, 0);
    chk("t5_in_ready", in_ready, 1);
    reset = 0; ttt_stage = 2'b00; step();
    chk("t5_idle", ttt_instruction, 0);
    step_req = 1; step(); step_req = 0;
    step();
    chk("t5_in_empty", ttt_instruction, 4'b0010);
    step();
    ttt_stage = 2'b01; step();
    ttt_stage = 2'b00; step();
    chk("t5_ack", step_ack, 1);
    chk("t5_count1", step_count, 1);

    // 6: stage stuck at 01
    step_req = 1; step(); step_req = 0;
    step();
    ttt_stage = 2'b01; step();
    err_at = -1; seen_ack = 0;
    for (int k = 1; k <= 2000; k++) begin
      step();
      if (step_ack) seen_ack = 1;
      if (seq_error && err_at < 0) err_at = k;
    end
    chk("t6_no_ack", 32'(seen_ack), 0);
    chk("t6_count", step_count, 1);
`ifdef TTT_SEQ_WATCHDOG_EN
    chk("t6_wd_cycle", 32'(err_at), 1024);
    chk("t6_err", seq_error, 1);
    chk("t6_instr", ttt_instruction, 0);
    ttt_stage = 2'b00; step();
    chk("t6_idle_no_ack", step_ack, 0);
    chk("t6_count_same", step_count, 1);
    chk("t6_err_sticky", seq_error, 1);
`else
    chk("t6_no_err_seen", 32'(err_at), 32'hFFFF_FFFF);
    chk("t6_err", seq_error, 0);
    ttt_stage = 2'b00; step();
    chk("t6_late_ack", step_ack, 1);
    chk("t6_late_count", step_count, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
